// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier between two requesters.
// Every output is a flop; the wait timer aborts a transaction the multiplier never finishes.
module mult_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        ack0,
  output logic        ack1,
  output logic        res_valid0,
  output logic        res_valid1,
  output logic [15:0] result,
  output logic        timeout_err,
  output logic        busy,
  output logic        m_start,
  output logic [7:0]  m_dataa,
  output logic [7:0]  m_datab,
  input  logic        m_done,
  input  logic [15:0] m_product
);

  // state | meaning
  // IDLE  | waiting for a request; grant and operand capture happen on leaving
  // START | one-cycle launch of the multiplier
  // WAIT  | waiting for m_done, bounded by the wait counter
  // RESP  | one-cycle result-valid pulse to the granted requester
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  dataa_q, dataa_d;
  logic [7:0]  datab_q, datab_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic        to_q, to_d, busy_q, busy_d, mstart_q, mstart_d;
  logic        win;

  // Contention goes to the requester not served last; a lone request always wins.
  assign win = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 16'd0;
      dataa_q  <= 8'd0;
      datab_q  <= 8'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
      mstart_q <= mstart_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    to_d     = 1'b0;
    mstart_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = START;
          gnt_d   = win;
          dataa_d = win ? a1 : a0;
          datab_d = win ? b1 : b0;
          ack0_d  = ~win;
          ack1_d  = win;
        end
      end
      START: begin
        state_d  = WAIT;
        cnt_d    = 5'd0;
        mstart_d = 1'b1;
      end
      WAIT: begin
        // done takes priority over a coincident timeout
        if (m_done) begin
          state_d  = RESP;
          result_d = m_product;
          last_d   = gnt_q;
          rv0_d    = ~gnt_q;
          rv1_d    = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          last_d  = gnt_q;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign res_valid0  = rv0_q;
  assign res_valid1  = rv1_q;
  assign result      = result_q;
  assign timeout_err = to_q;
  assign busy        = busy_q;
  assign m_start     = mstart_q;
  assign m_dataa     = dataa_q;
  assign m_datab     = datab_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: acts as the multiplier and predicts each transaction as a
// timeline fixed at grant time, then compares every output on every falling edge.
module tb_mult_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_a = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic        m_done = 1'b0;
  logic [15:0] m_product = 16'd0;
  logic        ack0, ack1, res_valid0, res_valid1, timeout_err, busy, m_start;
  logic [15:0] result;
  logic [7:0]  m_dataa, m_datab;

  mult_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_a(reset_a), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res_valid0(res_valid0), .res_valid1(res_valid1),
    .result(result), .timeout_err(timeout_err), .busy(busy), .m_start(m_start),
    .m_dataa(m_dataa), .m_datab(m_datab), .m_done(m_done), .m_product(m_product)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  // transaction record: granted at edge g to w; done sampled at edge g+2+d, or timeout
  bit txn = 0, w = 0, dn = 0, last = 1;
  int g = 0, d = 0, free_at = 0, grants = 0;
  logic [15:0] prod = 16'd0, exp_result = 16'd0;
  logic [7:0]  exp_da = 8'd0, exp_db = 8'd0;
  int dsel = -2;
  bit spur_en = 0, force_done = 0;

  bit          ack_who[$];
  bit          rv_who[$];
  logic [15:0] rv_res[$];
  int          to_cnt = 0, busy_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic clear_log();
    ack_who.delete(); rv_who.delete(); rv_res.delete();
    to_cnt = 0; busy_cnt = 0;
  endtask

  task automatic model_reset();
    txn = 0; last = 1; free_at = 0;
    exp_result = 16'd0; exp_da = 8'd0; exp_db = 8'd0;
  endtask

  task automatic model_edge();
    if (txn && dn && cyc == g + 2 + d) exp_result = prod;
    if (cyc >= free_at && (req0 || req1)) begin
      w = (req0 && req1) ? !last : req1;
      last = w;
      g = cyc; txn = 1; grants++;
      exp_da = w ? a1 : a0;
      exp_db = w ? b1 : b0;
      prod = 16'(exp_da) * 16'(exp_db);
      if (dsel == -1) dn = 0;
      else if (dsel >= 0) begin dn = 1; d = dsel; end
      else if ($urandom_range(0, 5) == 0) dn = 0;
      else begin dn = 1; d = $urandom_range(1, T - 1); end
      free_at = dn ? g + 4 + d : g + 2 + T;
    end
  endtask

  task automatic compare();
    int e;
    bit e_ack0, e_ack1, e_ms, e_busy, e_rv0, e_rv1, e_to;
    e = cyc;
    e_ack0 = txn && e == g && !w;
    e_ack1 = txn && e == g && w;
    e_ms   = txn && e == g + 1;
    e_busy = txn && e >= g && e <= (dn ? g + 2 + d : g + T);
    e_rv0  = txn && dn && e == g + 2 + d && !w;
    e_rv1  = txn && dn && e == g + 2 + d && w;
    e_to   = txn && !dn && e == g + 1 + T;
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("m_start", 32'(m_start), 32'(e_ms));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("res_valid0", 32'(res_valid0), 32'(e_rv0));
    chk("res_valid1", 32'(res_valid1), 32'(e_rv1));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    chk("result", 32'(result), 32'(exp_result));
    chk("m_dataa", 32'(m_dataa), 32'(exp_da));
    chk("m_datab", 32'(m_datab), 32'(exp_db));
    if (ack0) ack_who.push_back(1'b0);
    if (ack1) ack_who.push_back(1'b1);
    if (res_valid0 || res_valid1) begin
      rv_who.push_back(res_valid1);
      rv_res.push_back(result);
    end
    if (timeout_err) to_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic drive_done();
    int wend;
    m_product = 16'($urandom);
    m_done = 1'b0;
    if (txn && dn && cyc == g + 2 + d) begin
      m_done = 1'b1;
      m_product = prod;
    end else begin
      wend = dn ? g + 2 + d : g + 1 + T;
      if (spur_en && !(txn && cyc >= g + 2 && cyc <= wend) && $urandom_range(0, 7) == 0)
        m_done = 1'b1;
    end
    if (force_done) m_done = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_a) model_edge();
    @(negedge clk);
    compare();
    cyc++;
    drive_done();
  endtask

  task automatic do_reset(int n);
    reset_a = 1'b0;
    model_reset();
    #1;
    compare();
    chk("rst_now_busy", 32'(busy), 32'd0);
    chk("rst_now_result", 32'(result), 32'd0);
    repeat (n) step();
    reset_a = 1'b1;
  endtask

  task automatic wait_grant(bit who, int maxc);
    int n;
    n = 0;
    do begin step(); n++; end while (!(txn && g == cyc - 1 && w == who) && n < maxc);
    chk("grant_wait", 32'(txn && g == cyc - 1 && w == who), 32'd1);
  endtask

  task automatic finish_txn(int maxc);
    int n;
    n = 0;
    while (cyc < free_at && n < maxc) begin step(); n++; end
    chk("txn_end", 32'(cyc >= free_at), 32'd1);
  endtask

  initial begin
    int n0, n;
    step(); step();
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    reset_a = 1'b1;

    // single request from 0, known product
    clear_log();
    a0 = 8'h6E; b0 = 8'h0A; req0 = 1'b1; dsel = 3;
    wait_grant(1'b0, 10);
    req0 = 1'b0;
    chk("lit_ack0", 32'(ack0), 32'd1);
    step();
    chk("lit_mstart", 32'(m_start), 32'd1);
    chk("lit_ack0_gone", 32'(ack0), 32'd0);
    finish_txn(40);
    chk("lit032_model", 32'(exp_result), 32'h044C);
    chk("lit032_rvcount", 32'(rv_res.size()), 32'd1);
    if (rv_res.size() == 1) chk("lit032_dut", 32'(rv_res[0]), 32'h044C);

    // both requesters held high from reset: 0, 1, 0
    do_reset(2);
    clear_log();
    a0 = 8'hFF; b0 = 8'hFF; a1 = 8'h03; b1 = 8'h05; req0 = 1'b1; req1 = 1'b1; dsel = 2;
    n0 = grants; n = 0;
    while (grants < n0 + 3 && n < 100) begin step(); n++; end
    chk("rr_grants", 32'(grants - n0), 32'd3);
    req0 = 1'b0; req1 = 1'b0;
    finish_txn(40);
    chk("rr_rvcount", 32'(rv_res.size()), 32'd3);
    chk("rr_ackcount", 32'(ack_who.size()), 32'd3);
    if (rv_res.size() == 3 && ack_who.size() == 3) begin
      chk("rr_first_who", 32'(rv_who[0]), 32'd0);
      chk("rr_first_res", 32'(rv_res[0]), 32'hFE01);
      chk("rr_second_who", 32'(rv_who[1]), 32'd1);
      chk("rr_second_res", 32'(rv_res[1]), 32'h000F);
      chk("rr_third_ack", 32'(ack_who[2]), 32'd0);
      chk("rr_third_res", 32'(rv_res[2]), 32'hFE01);
    end

    // multiplier never answers
    clear_log();
    a0 = 8'h11; b0 = 8'h22; req0 = 1'b1; dsel = -1;
    wait_grant(1'b0, 10);
    req0 = 1'b0;
    finish_txn(60);
    chk("to_pulses", 32'(to_cnt), 32'd1);
    chk("to_no_rv", 32'(rv_res.size()), 32'd0);
    chk("to_result_kept", 32'(result), 32'hFE01);
    chk("to_busy_cycles", 32'(busy_cnt), 32'(T + 1));

    // reset in the middle of WAIT, then a clean transaction
    clear_log();
    a1 = 8'h40; b1 = 8'h02; req1 = 1'b1;
    wait_grant(1'b1, 10);
    req1 = 1'b0;
    repeat (6) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    do_reset(2);
    chk("mid_dataa", 32'(m_dataa), 32'd0);
    a0 = 8'h12; b0 = 8'h34; req0 = 1'b1; dsel = 2;
    wait_grant(1'b0, 10);
    req0 = 1'b0;
    finish_txn(40);
    chk("mid_to_none", 32'(to_cnt), 32'd0);
    chk("mid_rvcount", 32'(rv_res.size()), 32'd1);
    if (rv_res.size() == 1) chk("mid_res", 32'(rv_res[0]), 32'h03A8);

    // zero operand; busy spans ack through RESP
    clear_log();
    a1 = 8'h00; b1 = 8'hAB; req1 = 1'b1; dsel = 4;
    wait_grant(1'b1, 10);
    req1 = 1'b0;
    finish_txn(40);
    step(); step();
    chk("zero_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("zero_rvcount", 32'(rv_res.size()), 32'd1);
    if (rv_res.size() == 1) begin
      chk("zero_who", 32'(rv_who[0]), 32'd1);
      chk("zero_res", 32'(rv_res[0]), 32'h0000);
    end

    // stray m_done while idle
    clear_log();
    force_done = 1'b1;
    repeat (3) step();
    force_done = 1'b0;
    step(); step();
    chk("stray_no_rv", 32'(rv_res.size()), 32'd0);
    chk("stray_result", 32'(result), 32'h0000);
    chk("stray_idle", 32'(busy_cnt), 32'd0);

    // randomized traffic with stray dones and occasional resets
    spur_en = 1'b1; dsel = -2;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin
          req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
        end
      end else if (txn && g == cyc - 1 && !w) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else begin a0 = 8'($urandom); b0 = 8'($urandom); end
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin
          req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
        end
      end else if (txn && g == cyc - 1 && w) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else begin a1 = 8'($urandom); b1 = 8'($urandom); end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 TIMEOUT, 16: the maximum number of WAIT-state cycles allowed for m_done before the transaction is aborted.

Ports (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_a  in  1  reset; asynchronous, active-low.
REQ-004 req0 / req1  in  1 each  request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  in  8 each  operands of requester 0 / 1; held stable while req is high and ack has not yet been seen.
REQ-006 ack0 / ack1  out  1 each  one-cycle pulse: request accepted, operands captured.
REQ-007 res_valid0 / res_valid1  out  1 each  one-cycle pulse: result is valid for that requester.
REQ-008 result  out  16  product of the last completed transaction.
REQ-009 timeout_err  out  1  one-cycle pulse: the multiplier did not signal done within TIMEOUT cycles.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 m_start  out  1  start pulse to the shared seq_mult.
REQ-012 m_dataa / m_datab  out  8 each  operands to seq_mult; held constant from START through the end of WAIT.
REQ-013 m_done  in  1  done_flag from seq_mult.
REQ-014 m_product  in  16  product8x8_out from seq_mult.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have exactly four states:
- IDLE
- START
- WAIT
- RESP
REQ-017 In IDLE with any req high, the block SHALL grant one requester, latch its operands into m_dataa/m_datab, pulse its ack in the next cycle, and enter START.
REQ-018 Arbitration SHALL be round-robin:
- a pointer `last` (reset value 1) records the last requester served;
- when both requests are high, the requester other than `last` wins;
- when only one request is high, that requester wins regardless of `last`.
REQ-019 `last` SHALL update to the granted requester on leaving WAIT, whether the exit is by done or by timeout.
REQ-020 START SHALL last exactly 1 cycle with m_start=1, then go to WAIT; m_start SHALL be 0 in every other state.
REQ-021 On entry to WAIT, a 5-bit wait counter SHALL clear; it increments by 1 each WAIT cycle.
REQ-022 In WAIT with m_done=1, m_product SHALL be captured into result, and the FSM SHALL go to RESP.
REQ-023 In WAIT with m_done=0 and wait counter = TIMEOUT-1, the FSM SHALL pulse timeout_err for 1 cycle, leave result unchanged, assert no res_valid, and go to IDLE.
REQ-024 RESP SHALL last 1 cycle with res_validN=1 for the granted requester only, then go to IDLE.
REQ-025 In START, WAIT and RESP, req0/req1 SHALL be ignored; a request still high when the FSM is back in IDLE is treated as a new request.
REQ-026 m_done seen in IDLE, START or RESP SHALL be ignored.
REQ-027 If m_done and the timeout condition coincide, m_done SHALL win.
REQ-028 Latency: req sampled in IDLE at edge n gives ack at n+1 and m_start at n+2; res_valid follows m_done by one cycle.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle; the same holds for res_valid0 and res_valid1.

Reset
REQ-030 While reset_a=0, the block SHALL hold the following values; these values also apply in the same cycle reset_a falls:
- state = IDLE, `last` = 1, wait counter = 0;
- result = 0, m_dataa = 0, m_datab = 0;
- all other outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction without any res_valid or timeout_err pulse.

Verification
REQ-032 req0 with a0=0x6E, b0=0x0A against a seq_mult instance -> ack0 one cycle later, a single m_start pulse, then res_valid0 with result=0x044C.
REQ-033 req0 and req1 both held high, with (0xFF, 0xFF) and (0x03, 0x05) -> requester 0 served first with result 0xFE01, then requester 1 with result 0x000F, then requester 0 again.
REQ-034 m_done tied to 0 -> timeout_err pulses after TIMEOUT WAIT cycles, result is unchanged, the FSM returns to IDLE, and no res_valid pulse occurs.
REQ-035 reset_a dropped during WAIT -> all outputs are 0 immediately; after release, a new request completes correctly.
REQ-036 a1=0x00, b1=0xAB -> res_valid1 with result=0x0000; busy is high from the ack cycle through the RESP cycle.
REQ-037 Spurious m_done pulse in IDLE -> no res_valid pulse and no change to result.
